// File: rtl/cnt10_display_driver.sv
// Two-digit multiplexed 7-segment driver fed by a decade counter's BCD output.
// Detects the 9->0 ones wrap, keeps a tens digit and time-multiplexes both digits.
module cnt10_display_driver #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic [3:0] CNT10,
  output logic [6:0] SEG,
  output logic [1:0] AN,
  output logic [3:0] TENS,
  output logic       CARRY
);

  localparam int unsigned       SC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SC_W-1:0]   SC_LAST = SC_W'(SCAN_DIV - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [3:0]      prev_q, prev_d;
  logic [3:0]      tens_q, tens_d;
  logic            carry_q, carry_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic            sel_q, sel_d;
  logic [1:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            wrap_s;

  // Only an exact 9 followed by 0 counts; invalid codes still load prev so they block a carry
  assign wrap_s = (prev_q == 4'd9) && (CNT10 == 4'd0);

  // Next-state logic for wrap detection, tens digit, scan prescaler and display registers
  always_comb begin
    prev_d  = CNT10;
    carry_d = wrap_s;
    tens_d  = tens_q;
    sc_d    = sc_q;
    sel_d   = sel_q;
    an_d    = an_q;
    seg_d   = seg_q;

    if (wrap_s) begin
      if (tens_q == 4'd9) begin
        tens_d = 4'd0;
      end else begin
        tens_d = tens_q + 4'd1;
      end
    end else begin
      tens_d = tens_q;
    end

    if (sc_q == SC_LAST) begin
      sc_d  = '0;
      sel_d = ~sel_q;
    end else begin
      sc_d  = sc_q + SC_W'(1);
      sel_d = sel_q;
    end

    // AN and SEG come from the same sel so the digit and its pattern never disagree
    if (sel_q) begin
      an_d  = 2'b10;
      seg_d = seg_decode(tens_q);
    end else begin
      an_d  = 2'b01;
      seg_d = seg_decode(CNT10);
    end
  end

  // State and output registers with asynchronous active-low clear
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= 4'd0;
      tens_q  <= 4'd0;
      carry_q <= 1'b0;
      sc_q    <= '0;
      sel_q   <= 1'b0;
      an_q    <= 2'b01;
      seg_q   <= 7'b0000000;
    end else begin
      prev_q  <= prev_d;
      tens_q  <= tens_d;
      carry_q <= carry_d;
      sc_q    <= sc_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign SEG   = seg_q;
  assign AN    = an_q;
  assign TENS  = tens_q;
  assign CARRY = carry_q;

endmodule

// File: tb/tb_cnt10_display_driver.sv
// Scoreboard bench: two instances (SCAN_DIV 4 and 16) share stimulus; a closed-form
// model pushes expected outputs per edge which are popped and compared after the edge.
module tb_cnt10_display_driver;

  logic       Clk;
  logic       rst;
  logic [3:0] CNT10;
  logic [6:0] seg4, seg16;
  logic [1:0] an4, an16;
  logic [3:0] tens4, tens16;
  logic       carry4, carry16;

  cnt10_display_driver #(.SCAN_DIV(4)) dut4 (
    .Clk(Clk), .rst(rst), .CNT10(CNT10),
    .SEG(seg4), .AN(an4), .TENS(tens4), .CARRY(carry4)
  );

  cnt10_display_driver #(.SCAN_DIV(16)) dut16 (
    .Clk(Clk), .rst(rst), .CNT10(CNT10),
    .SEG(seg16), .AN(an16), .TENS(tens16), .CARRY(carry16)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [6:0] seg4;
    logic [1:0] an4;
    logic [6:0] seg16;
    logic [1:0] an16;
    logic [3:0] tens;
    logic       carry;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int m_prev   = 0;
  int m_tens   = 0;
  int m_k      = 0;
  int carry_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [6:0] tb_decode(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // digit selected on edge k (k counted from 1 after reset release)
  function automatic int sel_of(input int k, input int sd);
    return ((k - 1) / sd) % 2;
  endfunction

  task automatic model_reset();
    m_prev = 0;
    m_tens = 0;
    m_k    = 0;
  endtask

  // Drive v (called just after a negedge), predict, compare after the posedge, end at next negedge
  task automatic step(input int v);
    exp_t e;
    int   tens_old;
    bit   wrap;
    exp_t got;
    CNT10 = 4'(v);
    wrap     = (m_prev == 9) && (v == 0);
    tens_old = m_tens;
    if (wrap) m_tens = (m_tens + 1) % 10;
    m_prev = v;
    m_k++;
    e.an4   = (sel_of(m_k, 4)  == 1) ? 2'b10 : 2'b01;
    e.seg4  = (sel_of(m_k, 4)  == 1) ? tb_decode(tens_old) : tb_decode(v);
    e.an16  = (sel_of(m_k, 16) == 1) ? 2'b10 : 2'b01;
    e.seg16 = (sel_of(m_k, 16) == 1) ? tb_decode(tens_old) : tb_decode(v);
    e.tens  = 4'(m_tens);
    e.carry = wrap;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    got = exp_q.pop_front();
    check_eq("seg4",    32'(seg4),    32'(got.seg4));
    check_eq("an4",     32'(an4),     32'(got.an4));
    check_eq("seg16",   32'(seg16),   32'(got.seg16));
    check_eq("an16",    32'(an16),    32'(got.an16));
    check_eq("tens4",   32'(tens4),   32'(got.tens));
    check_eq("tens16",  32'(tens16),  32'(got.tens));
    check_eq("carry4",  32'(carry4),  32'(got.carry));
    check_eq("carry16", 32'(carry16), 32'(got.carry));
    if (carry4) carry_seen++;
    @(negedge Clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_seg4"},  32'(seg4),  32'd0);
    check_eq({tag, "_an4"},   32'(an4),   32'd1);
    check_eq({tag, "_tens4"}, 32'(tens4), 32'd0);
    check_eq({tag, "_carry"}, 32'(carry4), 32'd0);
    check_eq({tag, "_seg16"}, 32'(seg16), 32'd0);
    check_eq({tag, "_an16"},  32'(an16),  32'd1);
  endtask

  initial begin
    int guard;
    rst   = 1'b0;
    CNT10 = 4'd5;
    repeat (3) begin
      @(posedge Clk);
      #1;
      check_reset_state("rst_hold");
    end
    @(negedge Clk);
    rst = 1'b1;
    model_reset();

    step(5);
    for (int s = 0; s < 9; s++) begin
      for (int d = 0; d < 10; d++) step(d);
    end
    step(9); step(12); step(0);
    step(8); step(9); step(0); step(1);
    step(9); step(9); step(9); step(1); step(15); step(0);

    // TENS is 9 here; ten sweeps, each 0 preceded by a 9
    step(9);
    carry_seen = 0;
    for (int s = 0; s < 10; s++) begin
      for (int d = 0; d < 10; d++) step(d);
    end
    check_eq("carry_count", 32'(carry_seen), 32'd10);

    guard = 0;
    while (sel_of(m_k, 4) != 1 && guard < 20) begin
      step(7);
      guard++;
    end
    step(7);
    check_eq("pre_rst_an4", 32'(an4), 32'd2);
    #1 rst = 1'b0;
    #1;
    check_reset_state("mid_rst");
    #2 rst = 1'b1;
    model_reset();

    step(9); step(0); step(9); step(0); step(9); step(0);
    for (int i = 0; i < 24; i++) step(7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
